freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 5 +
 rtl/freq_meter_edge_sync.sv | 27 ++
 rtl/freq_meter.sv | 129 ++++++++++++
 tb/tb_freq_meter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default counter width for freq_meter.
package freq_meter_pkg;
    localparam int CNT_W_DEF = 32;
    typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: two-flop synchronizer plus previous-value register producing a one-cycle rising-edge pulse.
module edge_sync (
    input  logic fpga_clk,
    input  logic rst,
    input  logic d_in,
    output logic rise
);
    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;
    always_comb begin
        s1_d   = d_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end
    assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES window; define FREQ_METER_PERIOD_EN
// to add period_cycles, the fpga_clk cycles between the two most recent edges of the window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int FPGA_RATE   = 50000000,
    parameter int GATE_CYCLES = FPGA_RATE,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             fpga_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] freq_count,
    output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_cycles
`endif
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

    logic rise;
    state_t state_q, state_d;
    logic [GW-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d, freq_q, freq_d;
    logic ovf_q, ovf_d, overflow_q, overflow_d, valid_q, valid_d;

    edge_sync u_sync (
        .fpga_clk(fpga_clk),
        .rst     (rst),
        .d_in    (sig_in),
        .rise    (rise)
    );

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = MEASURE;
                gate_d  = '0;
                edge_d  = '0;
                ovf_d   = 1'b0;
            end
        end else begin
            gate_d = gate_q + 1'b1;
            if (rise) begin
                edge_d = &edge_q ? edge_q : edge_q + 1'b1;
                ovf_d  = ovf_q | (&edge_q);
            end
            // the edge seen in the final window cycle is folded into the latched result
            if (gate_q == GLAST) begin
                state_d    = IDLE;
                valid_d    = 1'b1;
                freq_d     = edge_d;
                overflow_d = ovf_d;
            end
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic seen_q, seen_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, period_q, period_d, pcnt_inc;
    always_comb begin
        seen_d   = seen_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        pcnt_inc = &pcnt_q ? pcnt_q : pcnt_q + 1'b1;
        if (state_q == IDLE) begin
            if (start) begin
                seen_d = 1'b0;
                pcnt_d = '0;
            end
        end else begin
            pcnt_d = rise ? '0 : pcnt_inc;
            if (rise) begin
                seen_d   = 1'b1;
                period_d = seen_q ? pcnt_inc : period_q;
            end
        end
    end
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            seen_q   <= 1'b0;
            pcnt_q   <= '0;
            period_q <= '0;
        end else begin
            seen_q   <= seen_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
        end
    end
    assign period_cycles = period_q;
`endif

    assign busy       = (state_q == MEASURE);
    assign valid      = valid_q;
    assign freq_count = freq_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter with a 32-bit and a saturating 4-bit instance.
module tb_freq_meter;
    localparam int GATE = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start4, sig_in;
    logic busy, valid, overflow, busy4, valid4, overflow4;
    logic [31:0] freq_count;
    logic [3:0] freq4;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] period_cycles;
    logic [3:0] period4;
`endif

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32)) dut (
        .fpga_clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .busy(busy), .valid(valid), .freq_count(freq_count), .overflow(overflow)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(period_cycles)
`endif
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
        .fpga_clk(clk), .rst(rst), .start(start4), .sig_in(sig_in),
        .busy(busy4), .valid(valid4), .freq_count(freq4), .overflow(overflow4)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(period4)
`endif
    );

    typedef struct {logic [31:0] c; logic o;} exp_t;
    exp_t q[$];
    exp_t q4[$];
    int vectors = 0;
    int errs = 0;
    int mode = 2;
    int per = 6;
    int ph = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("freq_count", freq_count, e.c);
                chk("overflow", {31'b0, overflow}, {31'b0, e.o});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid4 === 1'b1) begin
            if (q4.size() == 0) chk("unexpected_valid4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("freq_count4", {28'b0, freq4}, e.c);
                chk("overflow4", {31'b0, overflow4}, {31'b0, e.o});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        ph = (ph + 1) % per;
        sig_in = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (ph < per / 2);
    endtask

    // caller raises start (or start4) first; the window must close G+1 edges later
    task automatic run(input bit sel, input logic [31:0] c, input bit o, input bit extra);
        int n;
        int bc;
        exp_t e;
        e.c = c;
        e.o = o;
        if (sel) q4.push_back(e);
        else q.push_back(e);
        cyc();
        start = 1'b0;
        start4 = 1'b0;
        n = 1;
        bc = 0;
        while (!(sel ? valid4 : valid) && n < 300) begin
            if (sel ? busy4 : busy) bc++;
            if (extra && (n == 20 || n == 60)) start = 1'b1;
            cyc();
            start = 1'b0;
            n++;
        end
        chk("valid_latency", n, GATE + 1);
        chk("busy_cycles", bc, GATE);
        chk("busy_after", {31'b0, sel ? busy4 : busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        sig_in = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_freq", freq_count, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_busy4", {31'b0, busy4}, 32'd0);
        rst = 1'b0;
        per = 10;
        repeat (5) cyc();
        start = 1'b1;
        run(1'b0, 32'd10, 1'b0, 1'b0);
        start = 1'b1;
        run(1'b0, 32'd10, 1'b0, 1'b0);
        repeat (3) cyc();
        start = 1'b1;
        run(1'b0, 32'd10, 1'b0, 1'b1);
        cyc();
        chk("valid_pulse", {31'b0, valid}, 32'd0);
        repeat (20) cyc();
        chk("hold_freq", freq_count, 32'd10);
        per = 4;
        repeat (5) cyc();
        start = 1'b1;
        run(1'b0, 32'd25, 1'b0, 1'b0);
        start4 = 1'b1;
        run(1'b1, 32'd15, 1'b1, 1'b0);
        mode = 0;
        repeat (5) cyc();
        start = 1'b1;
        run(1'b0, 32'd0, 1'b0, 1'b0);
        mode = 1;
        repeat (5) cyc();
        start = 1'b1;
        run(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        start = 1'b1;
        run(1'b0, 32'd1, 1'b0, 1'b0);
        mode = 2;
        per = 10;
        repeat (5) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (49) cyc();
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
`ifdef FREQ_METER_PERIOD_EN
        chk("period", period_cycles, 32'd10);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_freq", freq_count, 32'd0);
        chk("abort_ovf4", {31'b0, overflow4}, 32'd0);
        repeat (150) cyc();
        chk("queue_empty", q.size() + q4.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
